// File: rtl/logic_reduce_sampler_if.sv
// Bundle of the control, data and valid/ready output signals for logic_reduce_sampler.
// The master side (stimulus/consumer) drives the inputs.
// The slave side (the sampler itself) drives the result and the status flags.
interface logic_reduce_sampler_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8
);
    logic                      en;
    logic [DIV_W-1:0]          div;
    logic [2:0]                op;
    logic [CHANNELS*WIDTH-1:0] din;
    logic                      out_ready;
    logic                      clr_ovr;
    logic [WIDTH-1:0]          dout;
    logic                      out_valid;
    logic                      changed;
    logic                      overrun;

    modport master (
        output en, div, op, din, out_ready, clr_ovr,
        input  dout, out_valid, changed, overrun
    );

    modport slave (
        input  en, div, op, din, out_ready, clr_ovr,
        output dout, out_valid, changed, overrun
    );
endinterface

// File: rtl/logic_reduce_sampler.sv
// Periodic multi-channel sampler with a selectable bitwise reduction.
// A programmable divider produces sample ticks.
// Stage 1 captures the channel words and op on a tick.
// Stage 2 reduces the captured words and loads a one-entry valid/ready output buffer.
// The buffer also provides change-detect and sticky overrun flags.
module logic_reduce_sampler #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    logic_reduce_sampler_if.slave  bus
);

    logic [DIV_W-1:0]          cnt;
    logic                      tick;
    logic [CHANNELS*WIDTH-1:0] s1_din;
    logic [2:0]                s1_op;
    logic                      s1_valid;
    logic [WIDTH-1:0]          red_and;
    logic [WIDTH-1:0]          red_or;
    logic [WIDTH-1:0]          red_xor;
    logic [WIDTH-1:0]          result;
    logic [WIDTH-1:0]          prev_result;
    logic [WIDTH-1:0]          dout_r;
    logic                      out_valid_r;
    logic                      changed_r;
    logic                      overrun_r;
    logic                      ovr_event;

    // The >= compare makes a div lowered below the running count tick on the next cycle.
    assign tick = bus.en && (cnt >= bus.div);

    // Sample divider: count up to div, wrap on tick, held at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!bus.en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Stage 1: capture channel words and reduction select on a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_din   <= '0;
            s1_op    <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= tick;
            if (tick) begin
                s1_din <= bus.din;
                s1_op  <= bus.op;
            end
        end
    end

    // Full-width reductions across all captured channels.
    // The inverting ops invert the complete reduction, not each stage.
    always_comb begin
        red_and = '1;
        red_or  = '0;
        red_xor = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            red_and = red_and & s1_din[i*WIDTH +: WIDTH];
            red_or  = red_or  | s1_din[i*WIDTH +: WIDTH];
            red_xor = red_xor ^ s1_din[i*WIDTH +: WIDTH];
        end
        case (s1_op)
            3'd1:    result = red_or;
            3'd2:    result = red_xor;
            3'd3:    result = ~red_and;
            3'd4:    result = ~red_or;
            3'd5:    result = ~red_xor;
            3'd6:    result = s1_din[WIDTH-1:0];
            default: result = red_and;
        endcase
    end

    // A new result overwrites a result that is still pending and not being accepted this cycle.
    assign ovr_event = s1_valid && out_valid_r && !bus.out_ready;

    // Stage 2: output buffer, change detect and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r      <= '0;
            prev_result <= '0;
            out_valid_r <= 1'b0;
            changed_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            changed_r <= s1_valid && (result != prev_result);
            if (s1_valid) begin
                dout_r      <= result;
                prev_result <= result;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (ovr_event) begin
                overrun_r <= 1'b1;
            end else if (bus.clr_ovr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign bus.dout      = dout_r;
    assign bus.out_valid = out_valid_r;
    assign bus.changed   = changed_r;
    assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_logic_reduce_sampler.sv
// Self-checking bench for logic_reduce_sampler (WIDTH=8, CHANNELS=4, DIV_W=8).
// Inputs are driven just after the falling edge and outputs are checked at the next falling edge.
// Expected values come from constants and from a per-edge behavioural model.
module tb_logic_reduce_sampler;
    localparam int W = 8;
    localparam int C = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // reference model state
    logic [7:0]  m_dout, m_prev, pend_res;
    logic        m_valid, m_chg, m_ovr, pend_tick;
    int          seg_n;
    logic [10:0] obs, expv;

    always #5 clk = ~clk;

    logic_reduce_sampler_if #(.WIDTH(W), .CHANNELS(C), .DIV_W(D)) bus();

    logic_reduce_sampler #(.WIDTH(W), .CHANNELS(C), .DIV_W(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // per-bit reduction from the count of ones among the four channels
    function automatic logic [7:0] ref_reduce(input logic [31:0] dn, input logic [2:0] o);
        logic [7:0] r;
        int ones;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            ones = 0;
            for (int k = 0; k < 4; k++) ones += int'(dn[k*8+j]);
            case (o)
                3'd1:    r[j] = (ones > 0);
                3'd2:    r[j] = ones[0];
                3'd3:    r[j] = (ones != 4);
                3'd4:    r[j] = (ones == 0);
                3'd5:    r[j] = !ones[0];
                3'd6:    r[j] = dn[j];
                default: r[j] = (ones == 4);
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_dout = '0; m_prev = '0; m_valid = 1'b0; m_chg = 1'b0; m_ovr = 1'b0;
        pend_tick = 1'b0; pend_res = '0; seg_n = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.div = '0; bus.op = '0; bus.din = '0;
        bus.out_ready = 1'b0; bus.clr_ovr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance the model across the rising edge, stop at the falling edge.
    task automatic cyc(input logic e, input logic [7:0] d, input logic [2:0] o,
                       input logic [31:0] dn, input logic r, input logic cl);
        logic       t;
        logic [7:0] res;
        bus.en = e; bus.div = d; bus.op = o; bus.din = dn;
        bus.out_ready = r; bus.clr_ovr = cl;
        if (!e) begin
            t = 1'b0;
            seg_n = 0;
        end else begin
            t = ((seg_n % (int'(d) + 1)) == int'(d));
            seg_n++;
        end
        res = ref_reduce(dn, o);
        @(posedge clk);
        if (pend_tick) begin
            if (m_valid && !r) m_ovr = 1'b1;
            else if (cl)       m_ovr = 1'b0;
            m_chg   = (pend_res != m_prev);
            m_prev  = pend_res;
            m_dout  = pend_res;
            m_valid = 1'b1;
        end else begin
            m_chg = 1'b0;
            if (m_valid && r) m_valid = 1'b0;
            if (cl)           m_ovr = 1'b0;
        end
        pend_tick = t;
        pend_res  = res;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
        total++;
        if (obs !== 11'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", obs, 11'h0);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 8'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
            obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
            total++;
            if (obs !== 11'h0) begin
                bad++;
                $display("FAIL en_off_idle c=%0d got=%h want=%h", i, obs, 11'h0);
            end
        end
    endtask

    task automatic test_ops();
        logic [31:0] dn;
        logic [2:0]  ops [4];
        logic [7:0]  exps [4];
        logic [7:0]  prev;
        dn = 32'hFF_F0_3C_FF;
        ops  = '{3'd1, 3'd2, 3'd3, 3'd6};
        exps = '{8'hFF, 8'hCC, 8'hCF, 8'hFF};
        do_reset();
        cyc(1'b1, 8'd0, 3'd0, dn, 1'b1, 1'b0);
        obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
        total++;
        if (obs !== 11'h0) begin
            bad++;
            $display("FAIL first_latency got=%h want=%h", obs, 11'h0);
        end
        cyc(1'b1, 8'd0, 3'd0, dn, 1'b1, 1'b0);
        obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
        total++;
        if (obs !== {8'h30, 3'b110}) begin
            bad++;
            $display("FAIL and_first got=%h want=%h", obs, {8'h30, 3'b110});
        end
        cyc(1'b1, 8'd0, 3'd0, dn, 1'b1, 1'b0);
        obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
        total++;
        if (obs !== {8'h30, 3'b100}) begin
            bad++;
            $display("FAIL and_repeat got=%h want=%h", obs, {8'h30, 3'b100});
        end
        prev = 8'h30;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'd0, ops[i], dn, 1'b1, 1'b0);
            obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
            total++;
            if (obs !== {prev, 3'b100}) begin
                bad++;
                $display("FAIL op%0d_hold got=%h want=%h", ops[i], obs, {prev, 3'b100});
            end
            cyc(1'b1, 8'd0, ops[i], dn, 1'b1, 1'b0);
            obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
            total++;
            if (obs !== {exps[i], 3'b110}) begin
                bad++;
                $display("FAIL op%0d_new got=%h want=%h", ops[i], obs, {exps[i], 3'b110});
            end
            cyc(1'b1, 8'd0, ops[i], dn, 1'b1, 1'b0);
            obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
            total++;
            if (obs !== {exps[i], 3'b100}) begin
                bad++;
                $display("FAIL op%0d_same got=%h want=%h", ops[i], obs, {exps[i], 3'b100});
            end
            prev = exps[i];
        end
        cyc(1'b0, 8'd0, 3'd0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 3'd0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_divider();
        int  nv;
        logic last_v;
        nv = 0;
        last_v = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'd3, 3'($urandom_range(0, 7)), $urandom, 1'b1, 1'b0);
            obs  = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
            expv = {m_dout, m_valid, m_chg, m_ovr};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL div3 c=%0d got=%h want=%h", i, obs, expv);
            end
            if (bus.out_valid === 1'b1) nv++;
            total++;
            if (last_v && bus.out_valid) begin
                bad++;
                $display("FAIL div3_pulse_width c=%0d got=2 want=1", i);
            end
            last_v = bus.out_valid;
        end
        total++;
        if (nv != 4) begin
            bad++;
            $display("FAIL div3_pulse_count got=%0d want=%0d", nv, 4);
        end
        cyc(1'b0, 8'd3, 3'd0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 8'd3, 3'd0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        logic [31:0] da, db, dc;
        da = $urandom; db = $urandom; dc = $urandom;
        do_reset();
        cyc(1'b1, 8'd0, 3'd2, da, 1'b0, 1'b0);
        cyc(1'b1, 8'd0, 3'd2, db, 1'b0, 1'b0);
        obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
        total++;
        if ({obs[10:3], obs[2], obs[0]} !== {ref_reduce(da, 3'd2), 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL ovr_first got=%h want_dout=%h", obs, ref_reduce(da, 3'd2));
        end
        cyc(1'b0, 8'd0, 3'd2, 32'h0, 1'b0, 1'b0);
        obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
        total++;
        if ({obs[10:3], obs[2], obs[0]} !== {ref_reduce(db, 3'd2), 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL ovr_set got=%h want_dout=%h ovr=1", obs, ref_reduce(db, 3'd2));
        end
        cyc(1'b0, 8'd0, 3'd2, 32'h0, 1'b0, 1'b1);
        total++;
        if ({bus.out_valid, bus.overrun} !== 2'b10) begin
            bad++;
            $display("FAIL ovr_clear got=%b want=%b", {bus.out_valid, bus.overrun}, 2'b10);
        end
        cyc(1'b1, 8'd0, 3'd2, dc, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 3'd2, 32'h0, 1'b0, 1'b1);
        total++;
        if ({bus.dout, bus.overrun} !== {ref_reduce(dc, 3'd2), 1'b1}) begin
            bad++;
            $display("FAIL ovr_beats_clr got=%h want=%h", {bus.dout, bus.overrun}, {ref_reduce(dc, 3'd2), 1'b1});
        end
        cyc(1'b0, 8'd0, 3'd2, 32'h0, 1'b1, 1'b1);
        total++;
        if ({bus.out_valid, bus.overrun} !== 2'b00) begin
            bad++;
            $display("FAIL ovr_accept_clear got=%b want=%b", {bus.out_valid, bus.overrun}, 2'b00);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        repeat (3) cyc(1'b1, 8'd0, 3'd1, 32'h01_02_04_08, 1'b1, 1'b0);
        total++;
        if ({bus.dout, bus.out_valid} !== {8'h0F, 1'b1}) begin
            bad++;
            $display("FAIL pre_reset got=%h want=%h", {bus.dout, bus.out_valid}, {8'h0F, 1'b1});
        end
        rst = 1'b1;
        bus.en = 1'b0;
        #1;
        obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
        total++;
        if (obs !== 11'h0) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", obs, 11'h0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'd0, 3'd1, 32'h01_02_04_08, 1'b1, 1'b0);
            obs = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
            total++;
            if (obs !== 11'h0) begin
                bad++;
                $display("FAIL post_reset_quiet c=%0d got=%h want=%h", i, obs, 11'h0);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            d = 8'($urandom_range(0, 4));
            for (int i = 0; i < 32; i++) begin
                if (i < 30)
                    cyc(1'b1, d, 3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0));
                else
                    cyc(1'b0, d, 3'd0, $urandom, 1'($urandom_range(0, 1)), 1'b0);
                obs  = {bus.dout, bus.out_valid, bus.changed, bus.overrun};
                expv = {m_dout, m_valid, m_chg, m_ovr};
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL random s=%0d c=%0d div=%0d got=%h want=%h", s, i, d, obs, expv);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_ops();
        test_divider();
        test_overrun();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
